cle_sram_arb: RTL and testbench

//  - Two-requester arbiter sharing the single-port sram_1024x8_t13 label memory inside CLE.
//  - Requester 0 is the raster labeling scan engine. Requester 1 is the label-merge/relabel engine.
//  - Drives sram_a/sram_d/sram_wen each cycle from the granted requester.
//  - Flags returning read data per requester; SRAM read latency is 1 cycle.

---
 rtl/cle_sram_arb.sv | 157 +++++++++++++++
 tb/tb_cle_sram_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cle_sram_arb.sv
`timescale 1ns/1ps
// Two-requester round-robin arbiter for the CLE single-port label SRAM.
// Define CLE_ARB_LOCK_EN to build burst lock (LOCK0/LOCK1 states and the lock counter).
module cle_sram_arb #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_MAX = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] sram_q,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen
);

  logic last_q, last_d;
  logic rvalid0_q, rvalid1_q;

`ifdef CLE_ARB_LOCK_EN
  localparam logic [1:0] StArb   = 2'd0;
  localparam logic [1:0] StLock0 = 2'd1;
  localparam logic [1:0] StLock1 = 2'd2;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
`else
  logic lock_unused;
  assign lock_unused = lock0 ^ lock1;
`endif

  // Grant decode: held low for the whole reset assertion, not just until the next edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef CLE_ARB_LOCK_EN
      if (state_q == StLock0) begin
        gnt0 = req0;
      end else if (state_q == StLock1) begin
        gnt1 = req1;
      end else
`endif
      begin
        if (req0 && req1) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    end
  end

  // Only the lock owner can be granted while locked, so last already equals the owner on exit.
  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

`ifdef CLE_ARB_LOCK_EN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      StLock0: begin
        cnt_d = cnt_inc;
        if (!lock0 || (cnt_inc == CW'(LOCK_MAX))) begin
          state_d = StArb;
          cnt_d   = '0;
        end
      end
      StLock1: begin
        cnt_d = cnt_inc;
        if (!lock1 || (cnt_inc == CW'(LOCK_MAX))) begin
          state_d = StArb;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StArb;
        if (gnt0 && lock0) begin
          state_d = StLock0;
          cnt_d   = CW'(1);
        end else if (gnt1 && lock1) begin
          state_d = StLock1;
          cnt_d   = CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StArb;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

  always_comb begin
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = 1'b1;
    if (gnt0) begin
      sram_a   = addr0;
      sram_d   = wdata0;
      sram_wen = ~we0;
    end else if (gnt1) begin
      sram_a   = addr1;
      sram_d   = wdata1;
      sram_wen = ~we1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = sram_q;

endmodule

// File: tb/tb_cle_sram_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for cle_sram_arb: random traffic against a behavioural arbiter and memory model.
module tb_cle_sram_arb;

  localparam int unsigned LMAX = 4;

  logic       clk, reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, sram_wen;
  logic [7:0] rdata, sram_q, sram_d;
  logic [9:0] sram_a;

  cle_sram_arb #(.AW(10), .DW(8), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .sram_q(sram_q),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, one cycle read latency.
  logic [7:0] sram_mem [1024];
  always @(posedge clk) begin
    if (!sram_wen) sram_mem[sram_a] <= sram_d;
    sram_q <= sram_mem[sram_a];
  end

  typedef struct {logic r; logic w; logic l; logic [9:0] a; logic [7:0] d;} req_t;
  typedef struct {logic g0; logic g1; logic rv0; logic rv1; logic wen; logic [9:0] a; logic [7:0] d;} exp_t;

  exp_t       exp_q[$];
  logic [7:0] rq0[$], rq1[$];
  logic [7:0] ref_mem [1024];
  int         n_cmp = 0, n_bad = 0;

  // Reference model: who owns a burst, how long it has lasted, who won most recently.
  int   m_owner, m_len, m_last, m_gnt;
  logic m_rv0, m_rv1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic r, input logic w, input logic [9:0] a,
                              input logic [7:0] d, input logic l);
    req_t t;
    t.r = r; t.w = w; t.a = a; t.d = d; t.l = l;
    return t;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_len = 0; m_last = 1; m_rv0 = 1'b0; m_rv1 = 1'b0;
    rq0.delete(); rq1.delete(); exp_q.delete();
  endtask

  task automatic apply(input req_t c0, input req_t c1);
    req_t cur[2];
    exp_t e;
    int   g;
    cur[0] = c0; cur[1] = c1;
    req0 = c0.r; we0 = c0.w; addr0 = c0.a; wdata0 = c0.d; lock0 = c0.l;
    req1 = c1.r; we1 = c1.w; addr1 = c1.a; wdata1 = c1.d; lock1 = c1.l;
    g = -1;
    if (m_owner >= 0) begin
      if (cur[m_owner].r) g = m_owner;
    end else if (c0.r && c1.r) g = (m_last == 0) ? 1 : 0;
    else if (c0.r) g = 0;
    else if (c1.r) g = 1;
    e.g0 = (g == 0); e.g1 = (g == 1);
    e.rv0 = m_rv0; e.rv1 = m_rv1;
    e.a = '0; e.d = '0; e.wen = 1'b1;
    if (g >= 0) begin
      e.a = cur[g].a; e.d = cur[g].d; e.wen = ~cur[g].w;
      if (cur[g].w) ref_mem[cur[g].a] = cur[g].d;
      else if (g == 0) rq0.push_back(ref_mem[cur[g].a]);
      else rq1.push_back(ref_mem[cur[g].a]);
    end
    m_rv0 = (g == 0) && !c0.w;
    m_rv1 = (g == 1) && !c1.w;
`ifdef CLE_ARB_LOCK_EN
    if (m_owner >= 0) begin
      m_len++;
      if (!cur[m_owner].l || m_len >= int'(LMAX)) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end else if (g >= 0 && cur[g].l) begin
      m_owner = g;
      m_len = 1;
    end
`endif
    if (g >= 0) m_last = g;
    m_gnt = g;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input req_t c0, input req_t c1);
    @(negedge clk);
    #1;
    apply(c0, c1);
  endtask

  // Monitor: compares every modelled cycle, pops read data whenever a read return is due.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("gnt0", 32'(gnt0), 32'(me.g0));
        chk("gnt1", 32'(gnt1), 32'(me.g1));
        chk("sram_a", 32'(sram_a), 32'(me.a));
        chk("sram_d", 32'(sram_d), 32'(me.d));
        chk("sram_wen", 32'(sram_wen), 32'(me.wen));
        chk("rvalid0", 32'(rvalid0), 32'(me.rv0));
        chk("rvalid1", 32'(rvalid1), 32'(me.rv1));
        if (me.rv0 && rq0.size() > 0) chk("rdata0", 32'(rdata), 32'(rq0.pop_front()));
        if (me.rv1 && rq1.size() > 0) chk("rdata1", 32'(rdata), 32'(rq1.pop_front()));
      end
    end
  end

  req_t idle, p[2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    idle = mk(1'b0, 1'b0, 10'h0, 8'h0, 1'b0);
    model_reset();
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h155; wdata0 = 8'h0; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 10'h0; wdata1 = 8'h0; lock1 = 1'b0;

    // Reset holds everything quiet even with a live request.
    @(negedge clk);
    #3;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_wen", 32'(sram_wen), 32'd1);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);

    // Release with both requesting: requester 0 wins the first tie.
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    apply(mk(1'b1, 1'b0, 10'h001, 8'h0, 1'b0), mk(1'b1, 1'b0, 10'h002, 8'h0, 1'b0));
    cyc(idle, idle);

    // Write then read back the same address.
    cyc(mk(1'b1, 1'b1, 10'h155, 8'h3A, 1'b0), idle);
    cyc(mk(1'b1, 1'b0, 10'h155, 8'h00, 1'b0), idle);
    cyc(mk(1'b0, 1'b0, 10'h0, 8'h0, 1'b0), mk(1'b1, 1'b1, 10'h0AA, 8'hC5, 1'b0));
    cyc(idle, idle);

    // Tie round-robin with reads on both sides.
    repeat (6) cyc(mk(1'b1, 1'b0, 10'h155, 8'h0, 1'b0), mk(1'b1, 1'b0, 10'h0AA, 8'h0, 1'b0));
    cyc(idle, idle);

    // Burst lock on requester 1 while requester 0 waits, then lock dropped.
    repeat (5) cyc(mk(1'b1, 1'b0, 10'h155, 8'h0, 1'b0), mk(1'b1, 1'b1, 10'h0AA, 8'h5A, 1'b1));
    repeat (2) cyc(mk(1'b1, 1'b0, 10'h155, 8'h0, 1'b0), mk(1'b1, 1'b0, 10'h0AA, 8'h0, 1'b0));
    cyc(idle, idle);

    // Long lock on requester 0 with requester 1 pending: forced release.
    repeat (10) cyc(mk(1'b1, 1'b1, 10'h010, 8'h77, 1'b1), mk(1'b1, 1'b0, 10'h010, 8'h0, 1'b0));
    cyc(idle, idle);

    // Random traffic; each requester holds its access until granted.
    p[0] = idle; p[1] = idle;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p[k].r) begin
          p[k].r = ($urandom_range(0, 3) != 0);
          p[k].w = 1'($urandom_range(0, 1));
          p[k].a = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 7))
                                               : 10'($urandom_range(0, 1023));
          p[k].d = 8'($urandom_range(0, 255));
          p[k].l = ($urandom_range(0, 2) != 0);
        end
      end
      cyc(p[0], p[1]);
      if (m_gnt >= 0) p[m_gnt].r = 1'b0;
    end
    repeat (3) cyc(idle, idle);

    // Reset in the cycle after a granted read discards the read return.
    cyc(mk(1'b1, 1'b0, 10'h155, 8'h0, 1'b0), idle);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #3;
    chk("midrst_gnt0", 32'(gnt0), 32'd0);
    chk("midrst_wen", 32'(sram_wen), 32'd1);
    chk("midrst_a", 32'(sram_a), 32'd0);
    chk("midrst_d", 32'(sram_d), 32'd0);
    chk("midrst_rvalid0", 32'(rvalid0), 32'd0);
    chk("midrst_rvalid1", 32'(rvalid1), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    apply(mk(1'b1, 1'b0, 10'h155, 8'h0, 1'b0), mk(1'b1, 1'b0, 10'h0AA, 8'h0, 1'b0));
    repeat (3) cyc(idle, idle);
    @(negedge clk);
    #4;
    chk("rq0_drained", 32'(rq0.size()), 32'd0);
    chk("rq1_drained", 32'(rq1.size()), 32'd0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
